// File: rtl/video_scanout.sv
// Raster scan-out: walks an H/V raster, fetches pixel-replicated buffer data, drives VGA pins.
// Latency: 2 clocks from raster counters to pins (fetch address/strobe, then syncs/blank/data).
// Backpressure: none; the buffer must return rdata on the clock after read, scan-out never stalls.
module video_scanout #(
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int SCALE_SHIFT = 2,
    parameter int PIX_W       = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic [7:0]       x,
    output logic [7:0]       y,
    output logic             read,
    input  logic [PIX_W-1:0] rdata,
    output logic             oVGA_HS,
    output logic             oVGA_VS,
    output logic             oVGA_BLANK,
    output logic [PIX_W-1:0] oVGA_DATA,
    output logic             frame_done
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Counters are at least 11 bits; wider only if the raster totals demand it.
    // The buffer is addressed with 8-bit x/y, so the scaled active area must fit in 256x256.
    localparam int HB = $clog2(H_TOTAL);
    localparam int VB = $clog2(V_TOTAL);
    localparam int MB = (HB > VB) ? HB : VB;
    localparam int CW = (MB > 11) ? MB : 11;

    localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] H_PRE_LAST = CW'(H_TOTAL - 2);
    localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT      = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT      = CW'(V_ACTIVE);
    localparam logic [CW-1:0] H_SYNC_BEG = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] H_SYNC_END = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] V_SYNC_BEG = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] V_SYNC_END = CW'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t        state;
    logic [CW-1:0] h_count;
    logic [CW-1:0] v_count;

    logic h_last;
    logic v_last;
    logic active;
    logic hs_n;
    logic vs_n;

    // Stage-1 copies of the raster timing, aligned with read/x/y.
    logic hs_s1;
    logic vs_s1;
    logic blank_s1;

    assign h_last = (h_count == H_LAST);
    assign v_last = (v_count == V_LAST);
    assign active = (state == S_RUN) && (h_count < H_ACT) && (v_count < V_ACT);
    assign hs_n   = !((state == S_RUN) && (h_count >= H_SYNC_BEG) && (h_count < H_SYNC_END));
    assign vs_n   = !((state == S_RUN) && (v_count >= V_SYNC_BEG) && (v_count < V_SYNC_END));

    // Scan FSM and raster counters; a stop request is only honoured on the last pixel of a frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            h_count    <= '0;
            v_count    <= '0;
            frame_done <= 1'b0;
        end else begin
            // Registered one clock early so the pulse lines up with the last raster position.
            frame_done <= (state == S_RUN) && v_last && (h_count == H_PRE_LAST);
            case (state)
                S_IDLE: begin
                    h_count <= '0;
                    v_count <= '0;
                    if (start) begin
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (h_last) begin
                        h_count <= '0;
                        if (v_last) begin
                            v_count <= '0;
                            if (!start) begin
                                state <= S_IDLE;
                            end
                        end else begin
                            v_count <= v_count + CW'(1);
                        end
                    end else begin
                        h_count <= h_count + CW'(1);
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    h_count <= '0;
                    v_count <= '0;
                end
            endcase
        end
    end

    // Stage 1: buffer fetch strobe and scaled address; address holds outside the active area.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            read     <= 1'b0;
            x        <= '0;
            y        <= '0;
            hs_s1    <= 1'b1;
            vs_s1    <= 1'b1;
            blank_s1 <= 1'b1;
        end else begin
            read     <= active;
            hs_s1    <= hs_n;
            vs_s1    <= vs_n;
            blank_s1 <= !active;
            if (active) begin
                x <= 8'(h_count >> SCALE_SHIFT);
                y <= 8'(v_count >> SCALE_SHIFT);
            end
        end
    end

    // Stage 2: pins, one clock behind the fetch so data and timing arrive together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            oVGA_HS    <= 1'b1;
            oVGA_VS    <= 1'b1;
            oVGA_BLANK <= 1'b1;
            oVGA_DATA  <= '0;
        end else begin
            oVGA_HS    <= hs_s1;
            oVGA_VS    <= vs_s1;
            oVGA_BLANK <= blank_s1;
            oVGA_DATA  <= read ? rdata : '0;
        end
    end

endmodule
